// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bus of the shared accumulator arbiter: request lines in, grant/status out.
interface shared_reg_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ID_W   = $clog2(N_REQ)
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        req_op;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic                    clear_ovf;
  logic [N_REQ-1:0]        gnt;
  logic [ID_W-1:0]         gnt_id;
  logic [DATA_W-1:0]       shared_q;
  logic                    ovf;
  logic                    busy;
  logic                    done;

  modport master (
    output req, req_op, req_data, clear_ovf,
    input  gnt, gnt_id, shared_q, ovf, busy, done
  );

  modport slave (
    input  req, req_op, req_data, clear_ovf,
    output gnt, gnt_id, shared_q, ovf, busy, done
  );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter giving N requesters single-writer access to one saturating
// accumulator; each transaction runs IDLE -> GRANT -> DONE.
module shared_reg_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ID_W   = $clog2(N_REQ)
) (
  input logic                clk,
  input logic                rst,
  shared_reg_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    DONE  = 2'b10
  } state_e;

  state_e            state_q;
  logic [N_REQ-1:0]  gnt_q;
  logic [ID_W-1:0]   gnt_id_q;
  logic [ID_W-1:0]   last_q;
  logic [DATA_W-1:0] shared_q;
  logic              ovf_q;
  logic              busy_q;
  logic              done_q;

  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic [N_REQ-1:0]  win_oh;
  int unsigned       cand;
  logic [DATA_W-1:0] op_data;
  logic [DATA_W:0]   sum;

  // Search starts one past the previous winner so priority rotates.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = (32'(last_q) + k) % N_REQ;
      if (!win_found && bus.req[ID_W'(cand)]) begin
        win_found = 1'b1;
        win_id    = ID_W'(cand);
      end
    end
    win_oh  = N_REQ'(1) << win_id;
    op_data = bus.req_data[gnt_id_q*DATA_W +: DATA_W];
    sum     = {1'b0, shared_q} + {1'b0, op_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      last_q   <= ID_W'(N_REQ - 1);
      shared_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Saturation below is assigned later, so it overrides a same-edge clear.
      if (bus.clear_ovf) ovf_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_found) begin
            gnt_id_q <= win_id;
            last_q   <= win_id;
            gnt_q    <= win_oh;
            busy_q   <= 1'b1;
            state_q  <= GRANT;
          end
        end
        GRANT: begin
          gnt_q <= '0;
          if (bus.req[gnt_id_q]) begin
            if (bus.req_op[gnt_id_q]) begin
              if (sum[DATA_W]) begin
                shared_q <= '1;
                ovf_q    <= 1'b1;
              end else begin
                shared_q <= sum[DATA_W-1:0];
              end
            end else begin
              shared_q <= op_data;
            end
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.gnt_id   = gnt_id_q;
  assign bus.shared_q = shared_q;
  assign bus.ovf      = ovf_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: grant latency, rotation, saturation, abort, reset.
module tb_shared_reg_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  shared_reg_arbiter_if #(.N_REQ(4), .DATA_W(4)) bus ();

  shared_reg_arbiter #(.N_REQ(4), .DATA_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs and samples happen 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Single-requester transaction; clr drives clear_ovf on the commit edge.
  task automatic txn(input int idx, input logic op, input logic [3:0] d, input logic clr);
    bus.req           = 4'(1 << idx);
    bus.req_op[idx]   = op;
    bus.req_data[idx*4 +: 4] = d;
    step();
    chk("txn_gnt", 32'(bus.gnt), 32'(1 << idx));
    bus.clear_ovf = clr;
    step();
    bus.clear_ovf = 1'b0;
    chk("txn_done", 32'(bus.done), 32'd1);
    bus.req = '0;
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.req       = '0;
    bus.req_op    = '0;
    bus.req_data  = '0;
    bus.clear_ovf = 1'b0;
    step();
    do_reset();

    chk("rst_gnt",    32'(bus.gnt),      32'h0);
    chk("rst_gnt_id", 32'(bus.gnt_id),   32'h0);
    chk("rst_shared", 32'(bus.shared_q), 32'h0);
    chk("rst_ovf",    32'(bus.ovf),      32'h0);
    chk("rst_busy",   32'(bus.busy),     32'h0);
    chk("rst_done",   32'(bus.done),     32'h0);

    // Latency: gnt at t+1, result and done at t+2, idle at t+3.
    bus.req      = 4'b0001;
    bus.req_op   = 4'b0000;
    bus.req_data = 16'h000A;
    step();
    chk("lat_gnt",  32'(bus.gnt),  32'b0001);
    chk("lat_busy", 32'(bus.busy), 32'h1);
    step();
    chk("lat_shared", 32'(bus.shared_q), 32'hA);
    chk("lat_done",   32'(bus.done),     32'h1);
    chk("lat_ovf",    32'(bus.ovf),      32'h0);
    bus.req = '0;
    step();
    chk("lat_idle_busy", 32'(bus.busy), 32'h0);
    chk("lat_idle_done", 32'(bus.done), 32'h0);

    // Rotation with all four requesting continuously.
    do_reset();
    bus.req      = 4'b1111;
    bus.req_op   = 4'b0000;
    bus.req_data = 16'h4321;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_gnt",    32'(bus.gnt),    32'(1 << (k % 4)));
      chk("rr_gnt_id", 32'(bus.gnt_id), 32'(k % 4));
      step();
      chk("rr_gnt_low", 32'(bus.gnt),      32'h0);
      chk("rr_done",    32'(bus.done),     32'h1);
      chk("rr_shared",  32'(bus.shared_q), 32'((k % 4) + 1));
      step();
      chk("rr_idle_gnt", 32'(bus.gnt),  32'h0);
      chk("rr_idle",     32'(bus.busy), 32'h0);
    end
    bus.req = '0;
    step();

    // Saturating add and sticky overflow.
    txn(1, 1'b0, 4'hC, 1'b0);
    chk("sat_load", 32'(bus.shared_q), 32'hC);
    txn(2, 1'b1, 4'h5, 1'b0);
    chk("sat_shared", 32'(bus.shared_q), 32'hF);
    chk("sat_ovf",    32'(bus.ovf),      32'h1);
    txn(3, 1'b1, 4'h0, 1'b0);
    chk("sticky_shared", 32'(bus.shared_q), 32'hF);
    chk("sticky_ovf",    32'(bus.ovf),      32'h1);
    bus.clear_ovf = 1'b1;
    step();
    bus.clear_ovf = 1'b0;
    chk("clear_ovf", 32'(bus.ovf), 32'h0);

    // Set beats clear on the same edge.
    txn(0, 1'b1, 4'h1, 1'b1);
    chk("set_wins_shared", 32'(bus.shared_q), 32'hF);
    chk("set_wins_ovf",    32'(bus.ovf),      32'h1);
    bus.clear_ovf = 1'b1;
    step();
    bus.clear_ovf = 1'b0;

    // Non-saturating add below the top value.
    txn(1, 1'b0, 4'h6, 1'b0);
    txn(2, 1'b1, 4'h7, 1'b0);
    chk("add_shared", 32'(bus.shared_q), 32'hD);
    chk("add_ovf",    32'(bus.ovf),      32'h0);

    // Abort: request withdrawn during GRANT.
    bus.req      = 4'b0001;
    bus.req_op   = 4'b0000;
    bus.req_data = 16'h0003;
    step();
    chk("abort_gnt", 32'(bus.gnt), 32'b0001);
    bus.req = '0;
    step();
    chk("abort_shared", 32'(bus.shared_q), 32'hD);
    chk("abort_done",   32'(bus.done),     32'h0);
    chk("abort_busy",   32'(bus.busy),     32'h0);
    chk("abort_gnt_lo", 32'(bus.gnt),      32'h0);
    step();
    chk("abort_done2", 32'(bus.done), 32'h0);

    // Reset during GRANT of an add discards the transaction.
    bus.req      = 4'b0010;
    bus.req_op   = 4'b0010;
    bus.req_data = 16'h0010;
    step();
    chk("rstg_gnt", 32'(bus.gnt), 32'b0010);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req = '0;
    chk("rstg_gnt0",   32'(bus.gnt),      32'h0);
    chk("rstg_gnt_id", 32'(bus.gnt_id),   32'h0);
    chk("rstg_shared", 32'(bus.shared_q), 32'h0);
    chk("rstg_ovf",    32'(bus.ovf),      32'h0);
    chk("rstg_busy",   32'(bus.busy),     32'h0);
    chk("rstg_done",   32'(bus.done),     32'h0);
    step();
    chk("rstg_stay_idle", 32'(bus.busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
